// File: rtl/vol_ramp.sv
// Stereo volume stage: per-sample gain ramp toward target (or zero on mute),
// 3-stage multiply / floor-shift / saturate pipeline.
module vol_ramp #(
  parameter int unsigned BIT       = 24,
  parameter int unsigned GAIN_INIT = 128
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SMP_EN,
  input  logic signed [BIT-1:0] in_L,
  input  logic signed [BIT-1:0] in_R,
  input  logic                  GAIN_WR,
  input  logic [7:0]            GAIN,
  input  logic                  MUTE,
  output logic signed [BIT-1:0] out_L,
  output logic signed [BIT-1:0] out_R,
  output logic                  out_valid,
  output logic                  ramping
);

  localparam int unsigned GW = 8;
  localparam int unsigned PW = BIT + 9;

  logic [GW-1:0]         tgt_q, tgt_d;
  logic [GW-1:0]         cur_q, cur_d;
  logic [GW-1:0]         eff;
  logic signed [BIT-1:0] s1_l_q, s1_l_d, s1_r_q, s1_r_d;
  logic [GW-1:0]         s1_g_q, s1_g_d;
  logic                  v1_q, v1_d;
  logic signed [PW-1:0]  p_l_q, p_l_d, p_r_q, p_r_d;
  logic                  v2_q, v2_d;
  logic signed [BIT-1:0] out_l_q, out_l_d, out_r_q, out_r_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ramping_q, ramping_d;

  // Floor-divide by 128, then clamp to the BIT-bit signed range.
  function automatic logic signed [BIT-1:0] scale_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] q;
    logic [PW-BIT:0]      hi;
    q  = p >>> 7;
    hi = q[PW-1:BIT-1];
    if (hi == '0 || hi == '1)
      scale_sat = q[BIT-1:0];
    else if (q[PW-1])
      scale_sat = {1'b1, {(BIT-1){1'b0}}};
    else
      scale_sat = {1'b0, {(BIT-1){1'b1}}};
  endfunction

  always_comb begin
    tgt_d       = tgt_q;
    cur_d       = cur_q;
    s1_l_d      = s1_l_q;
    s1_r_d      = s1_r_q;
    s1_g_d      = s1_g_q;
    p_l_d       = p_l_q;
    p_r_d       = p_r_q;
    out_l_d     = out_l_q;
    out_r_d     = out_r_q;
    eff         = MUTE ? GW'(0) : tgt_q;
    v1_d        = SMP_EN;
    v2_d        = v1_q;
    out_valid_d = v2_q;
    ramping_d   = (cur_q != eff);

    if (GAIN_WR)
      tgt_d = GAIN;

    // Stage 1 takes the gain before this strobe's step.
    if (SMP_EN) begin
      s1_l_d = in_L;
      s1_r_d = in_R;
      s1_g_d = cur_q;
      if (cur_q < eff)
        cur_d = cur_q + GW'(1);
      else if (cur_q > eff)
        cur_d = cur_q - GW'(1);
    end

    if (v1_q) begin
      p_l_d = PW'(s1_l_q) * PW'($signed({1'b0, s1_g_q}));
      p_r_d = PW'(s1_r_q) * PW'($signed({1'b0, s1_g_q}));
    end

    if (v2_q) begin
      out_l_d = scale_sat(p_l_q);
      out_r_d = scale_sat(p_r_q);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tgt_q       <= GW'(GAIN_INIT);
      cur_q       <= '0;
      s1_l_q      <= '0;
      s1_r_q      <= '0;
      s1_g_q      <= '0;
      v1_q        <= 1'b0;
      p_l_q       <= '0;
      p_r_q       <= '0;
      v2_q        <= 1'b0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      ramping_q   <= 1'b0;
    end else begin
      tgt_q       <= tgt_d;
      cur_q       <= cur_d;
      s1_l_q      <= s1_l_d;
      s1_r_q      <= s1_r_d;
      s1_g_q      <= s1_g_d;
      v1_q        <= v1_d;
      p_l_q       <= p_l_d;
      p_r_q       <= p_r_d;
      v2_q        <= v2_d;
      out_l_q     <= out_l_d;
      out_r_q     <= out_r_d;
      out_valid_q <= out_valid_d;
      ramping_q   <= ramping_d;
    end
  end

  assign out_L     = out_l_q;
  assign out_R     = out_r_q;
  assign out_valid = out_valid_q;
  assign ramping   = ramping_q;

endmodule

// File: doc/vol_ramp.md
# vol_ramp

Per-channel stereo volume stage with click-free gain ramping, sitting directly upstream of the 4-input stereo mixer adder (one instance per mixer input). It scales each signed stereo sample by an 8-bit unsigned gain, stepping the applied gain one LSB per sample toward a programmed target (or toward zero when muted). The product is saturated to BIT bits, so the stage itself never wraps. With gains ≤ 32 on all four channels, the downstream 4-input sum cannot overflow.

## Interface
- BIT, 24, sample width (signed two's complement)
- GAIN_INIT, 128, target gain loaded at reset (128 = unity)
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- SMP_EN  in  1  one-cycle sample strobe; in_L/in_R valid in this cycle
- in_L, in_R  in  BIT  signed input samples
- GAIN_WR  in  1  one-cycle pulse; latch GAIN into the target register
- GAIN  in  8  unsigned gain, Q1.7 (0 = silence, 128 = 1.0, 255 ≈ 1.992)
- MUTE  in  1  level; while high, effective target is 0
- out_L, out_R  out  BIT  signed scaled, saturated samples
- out_valid  out  1  one-cycle pulse; out_L/out_R updated this cycle
- ramping  out  1  high while applied gain ≠ effective target

## Operation
- Registers: tgt (8b), cur (8b, applied gain), stage-1 sample/gain regs, stage-2 product regs (BIT+9 signed), output regs, two valid bits.
- Effective target eff = MUTE ? 0 : tgt.
- GAIN_WR=1: tgt <= GAIN at that edge. Not qualified by SMP_EN.
- SMP_EN=1 edge:
  - Capture in_L, in_R, and the *pre-update* cur into stage 1.
  - Step cur: cur+1 if cur < eff, cur−1 if cur > eff, else hold. eff uses tgt before any same-edge GAIN_WR, and MUTE as sampled that cycle.
- cur changes only on SMP_EN edges. A full ramp takes |eff − cur| samples; e.g. 0→128 takes 128 samples.
- Stage 2: p = in × {1'b0, gain}, signed (BIT+9)-bit, exact.
- Stage 3: q = p >>> 7 (arithmetic, floor toward −∞). Saturate to [−2^(BIT−1), 2^(BIT−1)−1] and register to out_L/out_R.
- L and R always use the identical gain value.
- Gain 128 is bit-exact passthrough. Gain 0 gives 0.
- ramping is registered: ramping <= (cur ≠ eff), evaluated each cycle.
- MUTE toggling mid-ramp reverses direction at the next SMP_EN. There is no jump.
- out_L/out_R hold their value between out_valid pulses.

## Timing
- Reset values: out_L = out_R = 0, out_valid = 0, ramping = 0, cur = 0, tgt = GAIN_INIT, valid pipeline cleared.
- First cycle after reset: ramping = 1 if GAIN_INIT ≠ 0. Audio fades in from silence.
- Latency: SMP_EN at edge k → out regs updated and out_valid = 1 after edge k+2, for exactly one cycle.
- Fully pipelined: back-to-back SMP_EN accepted, giving back-to-back out_valid.
- RST mid-operation: in-flight samples are dropped (no out_valid for them), and cur and tgt are reinitialised. RST has priority over SMP_EN and GAIN_WR in the same cycle.
- GAIN_WR and SMP_EN in the same cycle: the sample uses the old cur, the step uses the old tgt, and the new tgt takes effect from the next SMP_EN.

## Test plan
- Reset, tgt = 128, in_L = 0x100000 on every SMP_EN → outputs 0x000000, 0x002000, 0x004000 … (gain 0, 1, 2, …). ramping drops 1 cycle after the 128th SMP_EN. Thereafter out = 0x100000 exactly.
- At unity, in_L = 0x7FFFFF, in_R = −0x800000 → out passes bit-exact. Write GAIN = 255 and let the ramp settle → out_L = 0x7FFFFF, out_R = 0x800000 (saturated). Unsaturated case: in = 0x000100 → 0x0001FE.
- Rounding: GAIN = 64 settled, in_L = −3 → out_L = −2. in_R = 3 → out_R = 1.
- MUTE asserted at cur = 128, then released after 40 samples → cur reaches 88, then climbs back to 128 over 40 samples. No output step exceeds 1 gain LSB per sample.
- SMP_EN every cycle for 10 cycles → 10 consecutive out_valid pulses, starting 2 cycles after the first strobe. GAIN_WR coincident with SMP_EN → that sample uses the old gain.
- RST pulsed 1 cycle after an SMP_EN → no out_valid follows. Outputs are 0 and cur = 0 after reset.
